// File: rtl/phase_sequencer.sv
// phase_sequencer: instruction phase FSM with debug stepping, halt/wake and
// a fetch-timeout watchdog. Every output flag is registered from the next
// state, so a flag is high in the same cycle the FSM occupies that state.
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   DEBUG_MODE_STOP,
//   DEBUG_AT_BKP,
//   DEBUG_IN_WATCH        debug stop sources (ORed into stop_cond)
//   DEBUG_REQ             level request for a debug step burst
//   DEBUG_STEP_COUNT      instructions per burst (0 behaves as 1)
//   DEBUG_MODE_INC        request memory-address increment with the ACK
//   HALTX                 current instruction is HALT (sampled in DECODE)
//   WAKE                  leave the halt state
//   MEM_READY             fetch data valid; FETCH stretches while low
//   STOPPED..COMMIT       one-hot phase flags
//   EXEC_IDX              EXECUTE cycle index, 0 outside EXECUTE
//   PC_ENX, HALTED, DEBUG_ACTIVE, DEBUG_ACK, DEBUG_MR_ADDR_INCX, BUS_ERR
//   STEPS_LEFT            remaining instructions in the current burst
module phase_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int STEP_W      = 8,
  parameter int WAIT_W      = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DEBUG_MODE_STOP,
  input  logic              DEBUG_AT_BKP,
  input  logic              DEBUG_IN_WATCH,
  input  logic              DEBUG_REQ,
  input  logic [STEP_W-1:0] DEBUG_STEP_COUNT,
  input  logic              DEBUG_MODE_INC,
  input  logic              HALTX,
  input  logic              WAKE,
  input  logic              MEM_READY,
  output logic              STOPPED,
  output logic              FETCH,
  output logic              DECODE,
  output logic              EXECUTE,
  output logic              COMMIT,
  output logic [3:0]        EXEC_IDX,
  output logic              PC_ENX,
  output logic              HALTED,
  output logic              DEBUG_ACTIVE,
  output logic              DEBUG_ACK,
  output logic              DEBUG_MR_ADDR_INCX,
  output logic              BUS_ERR,
  output logic [STEP_W-1:0] STEPS_LEFT
);

  // 4-bit encoding leaves spare codes that must recover to ST_STOP
  typedef enum logic [3:0] {
    ST_STOP     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC     = 4'd3,
    ST_COMMIT   = 4'd4,
    ST_HALT     = 4'd5,
    ST_DBG_STOP = 4'd6,
    ST_DBG_ACK  = 4'd7
  } state_t;

  // wait_cnt counts earlier stalled FETCH cycles; the 2^WAIT_W-1'th stall times out
  localparam logic [WAIT_W-1:0] WAIT_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};
  localparam logic [3:0]        EXEC_LAST = 4'(EXEC_CYCLES-1);

  state_t            state, state_n;
  logic [3:0]        exec_cnt, exec_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic [STEP_W-1:0] steps_n;
  logic              refetch, refetch_n;
  logic              halted_n;
  logic              ack_pend, ack_pend_n;   // burst finished, ACK after next fetch
  logic              bus_err_n;
  logic              stop_cond;

  assign stop_cond = DEBUG_MODE_STOP | DEBUG_AT_BKP | DEBUG_IN_WATCH;

  always_comb begin
    state_n    = state;
    exec_n     = exec_cnt;
    wait_n     = '0;
    steps_n    = STEPS_LEFT;
    refetch_n  = refetch;
    halted_n   = HALTED;
    ack_pend_n = ack_pend;
    bus_err_n  = 1'b0;
    case (state)
      ST_STOP: state_n = stop_cond ? ST_DBG_STOP : ST_FETCH;
      ST_FETCH: begin
        if (MEM_READY) begin
          if (ack_pend) begin
            state_n    = ST_DBG_ACK;
            ack_pend_n = 1'b0;
          end else if (stop_cond && STEPS_LEFT == '0) begin
            state_n = ST_DBG_STOP;
          end else begin
            state_n = ST_DECODE;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          bus_err_n = 1'b1;
          refetch_n = 1'b1;
          state_n   = ST_DBG_STOP;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      ST_DECODE: begin
        if (HALTX) halted_n = 1'b1;
        exec_n  = '0;
        state_n = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_cnt == EXEC_LAST) begin
          exec_n  = '0;
          state_n = ST_COMMIT;
        end else begin
          exec_n = exec_cnt + 1'b1;
        end
      end
      ST_COMMIT: begin
        if (STEPS_LEFT != '0) begin
          steps_n = STEPS_LEFT - 1'b1;
          if (STEPS_LEFT == STEP_W'(1)) ack_pend_n = 1'b1;
        end
        state_n = HALTED ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        if (WAKE) begin
          halted_n = 1'b0;
          state_n  = ST_FETCH;
        end
      end
      ST_DBG_STOP: begin
        if (DEBUG_REQ || !stop_cond) begin
          if (DEBUG_REQ)
            steps_n = (DEBUG_STEP_COUNT == '0) ? STEP_W'(1) : DEBUG_STEP_COUNT;
          // a timed-out fetch never delivered its instruction
          if (refetch) begin
            refetch_n = 1'b0;
            state_n   = ST_FETCH;
          end else begin
            state_n = ST_DECODE;
          end
        end
      end
      ST_DBG_ACK: if (!DEBUG_REQ) state_n = ST_DBG_STOP;
      default: begin
        state_n    = ST_STOP;
        exec_n     = '0;
        steps_n    = '0;
        refetch_n  = 1'b0;
        halted_n   = 1'b0;
        ack_pend_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_STOP;
      exec_cnt     <= '0;
      wait_cnt     <= '0;
      refetch      <= 1'b0;
      ack_pend     <= 1'b0;
      STEPS_LEFT   <= '0;
      HALTED       <= 1'b0;
      STOPPED      <= 1'b1;
      FETCH        <= 1'b0;
      DECODE       <= 1'b0;
      EXECUTE      <= 1'b0;
      COMMIT       <= 1'b0;
      EXEC_IDX     <= '0;
      PC_ENX       <= 1'b0;
      DEBUG_ACTIVE <= 1'b0;
      DEBUG_ACK    <= 1'b0;
      BUS_ERR      <= 1'b0;
    end else begin
      state        <= state_n;
      exec_cnt     <= exec_n;
      wait_cnt     <= wait_n;
      refetch      <= refetch_n;
      ack_pend     <= ack_pend_n;
      STEPS_LEFT   <= steps_n;
      HALTED       <= halted_n;
      STOPPED      <= state_n inside {ST_STOP, ST_DBG_STOP, ST_HALT};
      FETCH        <= state_n == ST_FETCH;
      DECODE       <= state_n == ST_DECODE;
      EXECUTE      <= state_n == ST_EXEC;
      COMMIT       <= state_n == ST_COMMIT;
      EXEC_IDX     <= (state_n == ST_EXEC) ? exec_n : 4'd0;
      PC_ENX       <= state_n inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_COMMIT};
      DEBUG_ACTIVE <= (state_n inside {ST_DBG_STOP, ST_DBG_ACK}) ||
                      steps_n != '0 || ack_pend_n;
      DEBUG_ACK    <= state_n == ST_DBG_ACK;
      BUS_ERR      <= bus_err_n;
    end
  end

  assign DEBUG_MR_ADDR_INCX = DEBUG_ACK & DEBUG_MODE_INC;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with EXEC_CYCLES=3, WAIT_W=4.
module tb_phase_sequencer;
  localparam int EC = 3;
  localparam logic [4:0] P_S = 5'b10000, P_F = 5'b01000, P_D = 5'b00100,
                         P_E = 5'b00010, P_C = 5'b00001;

  logic       CLK = 1'b0, RESET;
  logic       DEBUG_MODE_STOP, DEBUG_AT_BKP, DEBUG_IN_WATCH, DEBUG_REQ;
  logic [7:0] DEBUG_STEP_COUNT;
  logic       DEBUG_MODE_INC, HALTX, WAKE, MEM_READY;
  logic       STOPPED, FETCH, DECODE, EXECUTE, COMMIT;
  logic [3:0] EXEC_IDX;
  logic       PC_ENX, HALTED, DEBUG_ACTIVE, DEBUG_ACK, DEBUG_MR_ADDR_INCX, BUS_ERR;
  logic [7:0] STEPS_LEFT;

  int checks = 0, failures = 0;

  phase_sequencer #(.EXEC_CYCLES(EC), .STEP_W(8), .WAIT_W(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .DEBUG_MODE_STOP(DEBUG_MODE_STOP), .DEBUG_AT_BKP(DEBUG_AT_BKP),
    .DEBUG_IN_WATCH(DEBUG_IN_WATCH), .DEBUG_REQ(DEBUG_REQ),
    .DEBUG_STEP_COUNT(DEBUG_STEP_COUNT), .DEBUG_MODE_INC(DEBUG_MODE_INC),
    .HALTX(HALTX), .WAKE(WAKE), .MEM_READY(MEM_READY),
    .STOPPED(STOPPED), .FETCH(FETCH), .DECODE(DECODE), .EXECUTE(EXECUTE),
    .COMMIT(COMMIT), .EXEC_IDX(EXEC_IDX), .PC_ENX(PC_ENX), .HALTED(HALTED),
    .DEBUG_ACTIVE(DEBUG_ACTIVE), .DEBUG_ACK(DEBUG_ACK),
    .DEBUG_MR_ADDR_INCX(DEBUG_MR_ADDR_INCX), .BUS_ERR(BUS_ERR),
    .STEPS_LEFT(STEPS_LEFT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [4:0] ph();
    return {STOPPED, FETCH, DECODE, EXECUTE, COMMIT};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // D, E0..E2, C with STEPS_LEFT constant throughout the instruction
  task automatic run_instr(input string tag, input logic [7:0] steps_exp);
    tick(); chk({tag, "_D"}, ph(), P_D); chk({tag, "_D_steps"}, STEPS_LEFT, steps_exp);
    for (int i = 0; i < EC; i++) begin
      tick();
      chk($sformatf("%s_E%0d", tag, i), ph(), P_E);
      chk($sformatf("%s_E%0d_idx", tag, i), EXEC_IDX, i);
    end
    tick(); chk({tag, "_C"}, ph(), P_C); chk({tag, "_C_steps"}, STEPS_LEFT, steps_exp);
    chk({tag, "_C_idx"}, EXEC_IDX, 0);
  endtask

  initial begin
    RESET = 1; DEBUG_MODE_STOP = 0; DEBUG_AT_BKP = 0; DEBUG_IN_WATCH = 0;
    DEBUG_REQ = 0; DEBUG_STEP_COUNT = 0; DEBUG_MODE_INC = 0; HALTX = 0;
    WAKE = 0; MEM_READY = 1;
    tick(); tick();
    // reset state
    chk("rst_phase", ph(), P_S);
    chk("rst_pc", PC_ENX, 0);
    chk("rst_steps", STEPS_LEFT, 0);
    chk("rst_idx", EXEC_IDX, 0);
    chk("rst_misc", {HALTED, DEBUG_ACTIVE, DEBUG_ACK, DEBUG_MR_ADDR_INCX, BUS_ERR}, 0);

    // normal run flow
    RESET = 0;
    tick(); chk("run_F", ph(), P_F); chk("run_F_pc", PC_ENX, 1);
    run_instr("run1", 8'd0);
    tick(); chk("run_F2", ph(), P_F);
    run_instr("run2", 8'd0);
    tick(); chk("run_F3", ph(), P_F);

    // breakpoint during FETCH
    DEBUG_AT_BKP = 1;
    tick(); chk("bkp_stop", ph(), P_S); chk("bkp_active", DEBUG_ACTIVE, 1);
    chk("bkp_pc", PC_ENX, 0);
    tick(); chk("bkp_hold", ph(), P_S);

    // two-instruction burst
    DEBUG_REQ = 1; DEBUG_STEP_COUNT = 8'd2;
    run_instr("b2i1", 8'd2);
    chk("b2_active", DEBUG_ACTIVE, 1);
    tick(); chk("b2_F1", ph(), P_F); chk("b2_F1_steps", STEPS_LEFT, 1);
    run_instr("b2i2", 8'd1);
    tick(); chk("b2_F2", ph(), P_F); chk("b2_F2_steps", STEPS_LEFT, 0);
    chk("b2_F2_ack", DEBUG_ACK, 0); chk("b2_F2_active", DEBUG_ACTIVE, 1);
    tick(); chk("b2_ack1", DEBUG_ACK, 1); chk("b2_ack1_ph", ph(), 5'b00000);
    tick(); chk("b2_ack2", DEBUG_ACK, 1);
    DEBUG_REQ = 0;
    tick(); chk("b2_end_ack", DEBUG_ACK, 0); chk("b2_end_ph", ph(), P_S);
    chk("b2_end_active", DEBUG_ACTIVE, 1);

    // zero step count acts as one, with address increment
    DEBUG_STEP_COUNT = 8'd0; DEBUG_MODE_INC = 1; DEBUG_REQ = 1;
    run_instr("b0", 8'd1);
    tick(); chk("b0_F", ph(), P_F); chk("b0_F_steps", STEPS_LEFT, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("b0_ack%0d", i), DEBUG_ACK, 1);
      chk($sformatf("b0_inc%0d", i), DEBUG_MR_ADDR_INCX, 1);
    end
    DEBUG_REQ = 0;
    tick(); chk("b0_end_ack", DEBUG_ACK, 0); chk("b0_end_inc", DEBUG_MR_ADDR_INCX, 0);
    chk("b0_end_ph", ph(), P_S);
    DEBUG_MODE_INC = 0;

    // fetch timeout, then refetch
    DEBUG_AT_BKP = 0;
    run_instr("to_pre", 8'd0);
    MEM_READY = 0;
    tick(); chk("to_F1", ph(), P_F);
    for (int i = 2; i <= 15; i++) begin
      if (i == 15) DEBUG_AT_BKP = 1;
      tick();
      chk($sformatf("to_F%0d", i), ph(), P_F);
      chk($sformatf("to_F%0d_err", i), BUS_ERR, 0);
    end
    tick(); chk("to_err", BUS_ERR, 1); chk("to_stop", ph(), P_S);
    tick(); chk("to_err_pulse", BUS_ERR, 0); chk("to_hold", ph(), P_S);
    MEM_READY = 1; DEBUG_AT_BKP = 0;
    tick(); chk("to_refetch", ph(), P_F);
    tick(); chk("to_decode", ph(), P_D);

    // halt with simultaneous wake in DECODE
    HALTX = 1; WAKE = 1;
    tick(); chk("h_E0", ph(), P_E); chk("h_halted", HALTED, 1);
    HALTX = 0; WAKE = 0;
    tick(); tick();
    tick(); chk("h_C", ph(), P_C);
    DEBUG_AT_BKP = 1; DEBUG_REQ = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("h_halt%0d", i), ph(), P_S);
      chk($sformatf("h_halt%0d_hl", i), HALTED, 1);
      chk($sformatf("h_halt%0d_act", i), DEBUG_ACTIVE, 0);
    end
    DEBUG_REQ = 0; WAKE = 1;
    tick(); chk("h_wake_F", ph(), P_F); chk("h_wake_hl", HALTED, 0);
    WAKE = 0;

    // reset mid-burst
    tick(); chk("r_stop", ph(), P_S);
    DEBUG_REQ = 1; DEBUG_STEP_COUNT = 8'd3;
    tick(); chk("r_D", ph(), P_D); chk("r_steps", STEPS_LEFT, 3);
    tick(); tick(); chk("r_E1", EXEC_IDX, 1);
    RESET = 1;
    tick(); chk("r_ph", ph(), P_S); chk("r_steps0", STEPS_LEFT, 0);
    chk("r_ack", DEBUG_ACK, 0); chk("r_act", DEBUG_ACTIVE, 0); chk("r_pc", PC_ENX, 0);
    RESET = 0; DEBUG_REQ = 0; DEBUG_AT_BKP = 0;
    tick(); chk("r_F", ph(), P_F);
    for (int i = 0; i < 8; i++) begin
      tick(); chk($sformatf("r_noack%0d", i), DEBUG_ACK, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, number of EXECUTE cycles per instruction (legal 1..16).
REQ-002 Parameter STEP_W, default 8, width of the debug step counter.
REQ-003 Parameter WAIT_W, default 4, width of the fetch wait counter; the fetch timeout is 2^WAIT_W-1 cycles.
REQ-004 CLK  in  1  the single clock; all state changes on its rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 DEBUG_MODE_STOP, DEBUG_AT_BKP, DEBUG_IN_WATCH  in  1 each  debug stop sources; their OR is STOP_COND.
REQ-007 DEBUG_REQ  in  1  level request to execute a debug step burst.
REQ-008 DEBUG_STEP_COUNT  in  STEP_W  instructions per burst; 0 is treated as 1.
REQ-009 DEBUG_MODE_INC  in  1  requests a memory-address increment with the ACK.
REQ-010 HALTX  in  1  current instruction is HALT (valid in DECODE).
REQ-011 WAKE  in  1  leaves the halt state.
REQ-012 MEM_READY  in  1  fetch data valid; FETCH stretches while low.
REQ-013 STOPPED, FETCH, DECODE, EXECUTE, COMMIT  out  1 each  registered one-hot phase flags.
REQ-014 EXEC_IDX  out  4  index of the current EXECUTE cycle, 0..EXEC_CYCLES-1; 0 outside EXECUTE.
REQ-015 PC_ENX, HALTED, DEBUG_ACTIVE, DEBUG_ACK, DEBUG_MR_ADDR_INCX, BUS_ERR  out  1 each  status and handshake outputs.
REQ-016 STEPS_LEFT  out  STEP_W  remaining instructions in the current burst.

Function
REQ-017 States: STOP, FETCH, DECODE, EXEC, COMMIT, HALT, DBG_STOP, DBG_ACK. All outputs are registered from the next state, so a flag is high in the same cycle the FSM occupies that state.
REQ-018 Run flow: FETCH, DECODE, EXEC for exactly EXEC_CYCLES cycles, COMMIT, then back to FETCH. Instruction latency = 3+EXEC_CYCLES cycles when MEM_READY is high.
REQ-019 FETCH holds while MEM_READY=0. When it leaves FETCH with MEM_READY=1, it goes to DBG_STOP if STOP_COND=1 and no burst is active; otherwise it goes to DECODE.
REQ-020 Timeout: if MEM_READY stays 0 for 2^WAIT_W-1 consecutive FETCH cycles, the block pulses BUS_ERR for 1 cycle, sets an internal refetch flag and goes to DBG_STOP.
REQ-021 STOP (the post-reset state) goes to DBG_STOP if STOP_COND=1, else to FETCH.
REQ-022 DBG_STOP priority order:
- DEBUG_REQ=1: load STEPS_LEFT=max(DEBUG_STEP_COUNT,1) and go to DECODE, or to FETCH if the refetch flag is set (the flag is then cleared).
- Else STOP_COND=0: go to DECODE, or to FETCH if refetch is set.
- Else stay in DBG_STOP.
REQ-023 Burst: each COMMIT decrements STEPS_LEFT.
- At 1→0: go to FETCH, then DBG_ACK once the fetch completes.
- Otherwise continue the normal run flow.
- STOP_COND is ignored while STEPS_LEFT≠0.
REQ-024 DBG_ACK holds DEBUG_ACK=1 until DEBUG_REQ=0, then goes to DBG_STOP. DEBUG_MR_ADDR_INCX = DEBUG_ACK & DEBUG_MODE_INC.
REQ-025 HALTX=1 sampled in DECODE sets HALTED=1. After COMMIT the FSM goes to HALT instead of FETCH; HALT goes to FETCH on WAKE=1, clearing HALTED in the same cycle. STOP_COND and DEBUG_REQ are ignored in HALT.
REQ-026 DEBUG_ACTIVE=1 in DBG_STOP and DBG_ACK, and throughout a burst; it is 0 otherwise.
REQ-027 PC_ENX=1 only in FETCH/DECODE/EXEC/COMMIT, and it is 0 in the first cycle after reset release.
REQ-028 STOPPED=1 in STOP, DBG_STOP and HALT.
REQ-029 Simultaneous events: a timeout beats STOP_COND, DEBUG_REQ beats STOP_COND release, and WAKE with HALTX in the same cycle has no effect until HALT is entered.
REQ-030 Illegal or unreachable state encodings go to STOP on the next clock.

Reset
REQ-031 While RESET=1 at a clock edge:
- State is STOP with STOPPED=1.
- All other outputs are 0, STEPS_LEFT=0, EXEC_IDX=0.
- The refetch flag and the wait counter are cleared.
REQ-032 RESET asserted mid-instruction or mid-burst aborts it with no DEBUG_ACK. The first cycle after release is STOP, with PC_ENX=0.

Verification
REQ-033 Set EXEC_CYCLES=3, MEM_READY=1, all debug inputs 0, and release reset → STOP, F, D, E0, E1, E2, C, F repeating; PC_ENX first high in FETCH.
REQ-034 Raise DEBUG_AT_BKP=1 during FETCH → DBG_STOP with DEBUG_ACTIVE=1. Then DEBUG_REQ=1 with DEBUG_STEP_COUNT=2 → two instructions, then F, then DEBUG_ACK held until DEBUG_REQ=0, then DBG_STOP. STEPS_LEFT reads 2,1,0.
REQ-035 DEBUG_STEP_COUNT=0 with DEBUG_MODE_INC=1 → exactly one instruction runs, DEBUG_ACK and DEBUG_MR_ADDR_INCX are high together, and the ACK holds 3 cycles while DEBUG_REQ stays high 3 more cycles.
REQ-036 With WAIT_W=4, hold MEM_READY=0 for 15 FETCH cycles → a BUS_ERR 1-cycle pulse, then DBG_STOP. Clear STOP_COND → FETCH (refetch), not DECODE.
REQ-037 HALTX=1 in DECODE → HALTED=1, then COMMIT, then HALT with STOPPED=1 for 5 cycles. WAKE=1 → FETCH and HALTED=0.
REQ-038 Assert RESET during E1 of a burst with STEPS_LEFT=3 → next cycle STOP, STEPS_LEFT=0, no DEBUG_ACK.
